// File: rtl/jk_secuenciador_pkg.sv
// Shared codes for the JK bank sequencer: mode encodings and FSM states.
package jk_secuenciador_pkg;

    typedef logic [1:0] modo_t;

    // Sequence modes selected by modo
    localparam modo_t MODO_UP   = 2'b00;
    localparam modo_t MODO_DOWN = 2'b01;
    localparam modo_t MODO_GRAY = 2'b10;
    localparam modo_t MODO_LOAD = 2'b11;

    // FSM state encodings (also visible on the debug output)
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;

endpackage

// File: rtl/jk_secuenciador_if.sv
// Bundle between control logic / flip-flop bank (master) and the sequencer (slave).
// Handshake: start is a one-cycle request that is accepted only while busy=0;
// a request seen while busy=1 is dropped. Every accepted start produces exactly
// one done pulse, during which busy is still 1. j/k are only non-zero while busy.
interface jk_secuenciador_if
    import jk_secuenciador_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 8
);
    logic          en;
    logic          start;
    modo_t         modo;
    logic [PW-1:0] pasos;
    logic [N-1:0]  dato;
    logic [N-1:0]  q_fb;
    logic [N-1:0]  j;
    logic [N-1:0]  k;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output en, start, modo, pasos, dato, q_fb,
        input  j, k, busy, done, err
    );

    modport slave (
        input  en, start, modo, pasos, dato, q_fb,
        output j, k, busy, done, err
    );
endinterface

// File: rtl/jk_secuenciador_excitacion.sv
// Combinational JK excitation: drives each flip-flop toward its target bit.
// Only set (j) or reset (k) is ever issued; toggle is never produced.
module jk_excitacion #(
    parameter int N = 4
) (
    input  logic         activo,
    input  logic [N-1:0] q_fb,
    input  logic [N-1:0] objetivo,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);

    // Set bits that must rise, reset bits that must fall, hold the rest
    always_comb begin
        j = '0;
        k = '0;
        if (activo) begin
            j = ~q_fb & objetivo;
            k = q_fb & ~objetivo;
        end
    end

endmodule

// File: rtl/jk_secuenciador.sv
// Sequencer stepping an external JK flip-flop bank through up/down/Gray/load
// sequences, and flagging (sticky err) any step the bank failed to follow.
module jk_secuenciador
    import jk_secuenciador_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_secuenciador_if.slave bus,
    output logic [1:0]       estado
);

    localparam logic [N-1:0]  UNO_N  = N'(1);
    localparam logic [PW-1:0] UNO_PW = PW'(1);

    logic [1:0]    estado_r;
    modo_t         modo_r;
    logic [N-1:0]  dato_r;
    logic [N-1:0]  objetivo;
    logic [N-1:0]  esperado;
    logic [PW-1:0] cnt;
    logic          paso_previo;  // an enabled step happened on the previous edge
    logic          err_r;
    logic          activo;

    // Next value of the sequence for the given mode; Gray steps via binary
    function automatic logic [N-1:0] sig_valor(input logic [N-1:0] x,
                                               input modo_t        m,
                                               input logic [N-1:0] d);
        logic [N-1:0] b;
        logic [N-1:0] r;
        b = '0;
        r = '0;
        case (m)
            MODO_UP:   r = x + UNO_N;
            MODO_DOWN: r = x - UNO_N;
            MODO_GRAY: begin
                b[N-1] = x[N-1];
                for (int i = N - 2; i >= 0; i--) begin
                    b[i] = b[i+1] ^ x[i];
                end
                b = b + UNO_N;
                r = b ^ (b >> 1);
            end
            default:   r = d;
        endcase
        return r;
    endfunction

    // FSM, sequence registers and sticky divergence check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r    <= ST_IDLE;
            modo_r      <= MODO_UP;
            dato_r      <= '0;
            objetivo    <= '0;
            esperado    <= '0;
            cnt         <= '0;
            paso_previo <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (estado_r)
                ST_IDLE: begin
                    paso_previo <= 1'b0;
                    if (bus.start) begin
                        modo_r   <= bus.modo;
                        dato_r   <= bus.dato;
                        objetivo <= sig_valor(bus.q_fb, bus.modo, bus.dato);
                        cnt      <= (bus.modo == MODO_LOAD) ? UNO_PW : bus.pasos;
                        err_r    <= 1'b0;
                        // A zero-length run still reports completion through CHECK
                        if (bus.pasos == '0 && bus.modo != MODO_LOAD) begin
                            estado_r <= ST_CHECK;
                        end else begin
                            estado_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (paso_previo && bus.q_fb != esperado) begin
                        err_r <= 1'b1;
                    end
                    if (bus.en) begin
                        esperado    <= objetivo;
                        objetivo    <= sig_valor(objetivo, modo_r, dato_r);
                        cnt         <= cnt - UNO_PW;
                        paso_previo <= 1'b1;
                        if (cnt == UNO_PW) begin
                            estado_r <= ST_CHECK;
                        end
                    end else begin
                        paso_previo <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (paso_previo && bus.q_fb != esperado) begin
                        err_r <= 1'b1;
                    end
                    paso_previo <= 1'b0;
                    estado_r    <= ST_IDLE;
                end
                default: begin
                    paso_previo <= 1'b0;
                    estado_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Excitation only while stepping; reset forces IDLE so j/k drop at once
    assign activo = (estado_r == ST_RUN) && bus.en;

    jk_excitacion #(.N(N)) u_excitacion (
        .activo   (activo),
        .q_fb     (bus.q_fb),
        .objetivo (objetivo),
        .j        (bus.j),
        .k        (bus.k)
    );

    assign bus.busy = (estado_r == ST_RUN) || (estado_r == ST_CHECK);
    assign bus.done = (estado_r == ST_CHECK);
    assign bus.err  = err_r;
    assign estado   = estado_r;

endmodule
